// File: rtl/dram_pkg.sv
// Shared types and helpers for the DRAM command responder.
// Command/state enums, bus widths and the strobe decoder.
package dram_pkg;

    localparam int DRAM_A_W    = 12;
    localparam int DRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_COL,
        CMD_PRE
    } dram_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATING,
        ST_ACTIVE,
        ST_PRECHARGING
    } dram_state_e;

    // Chip select gates everything; RAS/CAS pick the command.
    function automatic dram_cmd_e decode_cmd(
        input logic csn,
        input logic rasn,
        input logic casn
    );
        dram_cmd_e c;
        c = CMD_NOP;
        if (!csn) begin
            unique case ({rasn, casn})
                2'b01:   c = CMD_ACT;
                2'b10:   c = CMD_COL;
                2'b00:   c = CMD_PRE;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// CAS-latency read pipeline: shifts {valid, data} CAS_LAT stages.
// Ports: clk, rst (async, high), in_valid/in_data in; q/q_valid out.
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int CAS_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DRAM_DATA_W-1:0] in_data,
    output logic [DRAM_DATA_W-1:0] q,
    output logic                   q_valid
);

    logic [CAS_LAT-1:0]     vld;
    logic [DRAM_DATA_W-1:0] dat [CAS_LAT];

    logic [CAS_LAT-1:0]     v_in;
    logic [DRAM_DATA_W-1:0] d_in [CAS_LAT];

    always_comb begin
        v_in = '0;
        d_in = '{default: '0};
        v_in[0] = in_valid;
        d_in[0] = in_data;
        for (int i = 1; i < CAS_LAT; i++) begin
            v_in[i] = vld[i-1];
            d_in[i] = dat[i-1];
        end
    end

    // Data stages only load with a valid beat, so the last stage
    // holds the previous read value while q_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < CAS_LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld <= v_in;
            for (int i = 0; i < CAS_LAT; i++) begin
                if (v_in[i]) begin
                    dat[i] <= d_in[i];
                end
            end
        end
    end

    assign q       = dat[CAS_LAT-1];
    assign q_valid = vld[CAS_LAT-1];

endmodule

// File: rtl/dram_responder.sv
// Device-side DRAM responder: row FSM, tRCD/tRP timing, array, CL pipe.
// Ports: clk, rst, DRAM_CSn/RASn/CASn/WEn/A/D in; DRAM_Q, q_valid,
//        row_open, protocol_err out.
module dram_responder
    import dram_pkg::*;
#(
    parameter int ROW_W   = 6,
    parameter int COL_W   = 6,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 1,
    parameter int CAS_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   DRAM_CSn,
    input  logic                   DRAM_RASn,
    input  logic                   DRAM_CASn,
    input  logic [3:0]             DRAM_WEn,
    input  logic [DRAM_A_W-1:0]    DRAM_A,
    input  logic [DRAM_DATA_W-1:0] DRAM_D,
    output logic [DRAM_DATA_W-1:0] DRAM_Q,
    output logic                   q_valid,
    output logic                   row_open,
    output logic                   protocol_err
);

    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;
    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DRAM_DATA_W-1:0] mem [DEPTH];

    dram_cmd_e        cmd;
    dram_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row_q;

    logic             col_ok;
    logic             wr;
    logic             rd;
    logic [AW-1:0]    addr;
    logic [DRAM_DATA_W-1:0] rd_data;

    // High address bits beyond ROW_W/COL_W carry no meaning.
    logic unused_a;
    assign unused_a = ^DRAM_A;

    assign cmd    = decode_cmd(DRAM_CSn, DRAM_RASn, DRAM_CASn);
    assign col_ok = (state == ST_ACTIVE) && (cmd == CMD_COL);
    assign wr     = col_ok && (DRAM_WEn != 4'hF);
    assign rd     = col_ok && (DRAM_WEn == 4'hF);
    assign addr   = {row_q, DRAM_A[COL_W-1:0]};
    assign rd_data = mem[addr];

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!DRAM_WEn[b]) begin
                    mem[addr][8*b +: 8] <= DRAM_D[8*b +: 8];
                end
            end
        end
    end

    // The timer keeps running on an illegal command; only the
    // command itself is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            row_q        <= '0;
            row_open     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            protocol_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd == CMD_ACT) begin
                        row_q <= DRAM_A[ROW_W-1:0];
                        if (T_RCD == 1) begin
                            state    <= ST_ACTIVE;
                            row_open <= 1'b1;
                        end else begin
                            cnt   <= RCD_LD;
                            state <= ST_ACTIVATING;
                        end
                    end else if (cmd == CMD_COL) begin
                        protocol_err <= 1'b1;
                    end
                end
                ST_ACTIVATING: begin
                    protocol_err <= (cmd != CMD_NOP);
                    cnt          <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state    <= ST_ACTIVE;
                        row_open <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cmd == CMD_ACT) begin
                        row_q <= DRAM_A[ROW_W-1:0];
                        if (T_RCD != 1) begin
                            cnt      <= RCD_LD;
                            state    <= ST_ACTIVATING;
                            row_open <= 1'b0;
                        end
                    end else if (cmd == CMD_PRE) begin
                        row_open <= 1'b0;
                        if (T_RP == 1) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= RP_LD;
                            state <= ST_PRECHARGING;
                        end
                    end
                end
                ST_PRECHARGING: begin
                    protocol_err <= (cmd == CMD_ACT) ||
                                    (cmd == CMD_COL);
                    cnt          <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dram_rd_pipe #(
        .CAS_LAT (CAS_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd),
        .in_data  (rd_data),
        .q        (DRAM_Q),
        .q_valid  (q_valid)
    );

endmodule
